// File: rtl/mult_seq_pkg.sv
// Shared constants for the sequential multiplier: FSM encodings and defaults.
package mult_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 4;

endpackage

// File: rtl/mult_seq_cla.sv
// WIDTH-bit carry look-ahead adder: per-bit generate/propagate cells grouped
// in pairs, with a group look-ahead chain over the pair G/P terms.
module cla_adder_w #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic [WIDTH-1:0] S,
  output logic             Co
);

  localparam int NGRP = WIDTH / 2;

  logic [WIDTH-1:0] g, p;

  assign g = A & B;
  assign p = A ^ B;

  // Pair-wise group look-ahead: each group carry comes from the previous
  // group's G/P, and the odd bit inside a pair is resolved from its even bit.
  always_comb begin
    logic cg;
    logic c_odd;
    logic grp_g, grp_p;
    S  = '0;
    cg = Ci;
    for (int k = 0; k < NGRP; k++) begin
      c_odd      = g[2*k] | (p[2*k] & cg);
      S[2*k]     = p[2*k] ^ cg;
      S[2*k+1]   = p[2*k+1] ^ c_odd;
      grp_g      = g[2*k+1] | (p[2*k+1] & g[2*k]);
      grp_p      = p[2*k+1] & p[2*k];
      cg         = grp_g | (grp_p & cg);
    end
    Co = cg;
  end

endmodule

// File: rtl/mult_seq.sv
// Iterative radix-2 shift-add multiplier; signed operands are handled by
// multiplying magnitudes and negating the 2*WIDTH result at the end.
module mult_seq
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [WIDTH-1:0]   add_a, add_b, add_s;
  logic               add_ci, add_co;

  // Single adder shared between the partial-product add and the final negate.
  cla_adder_w #(.WIDTH(WIDTH)) u_cla (
    .A  (add_a),
    .B  (add_b),
    .Ci (add_ci),
    .S  (add_s),
    .Co (add_co)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
    end
  end

  // Next-state, adder operand mux and datapath updates.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    add_a    = acc_q;
    add_b    = '0;
    add_ci   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Magnitude of -2^(WIDTH-1) wraps to 2^(WIDTH-1), exact as unsigned.
          mcand_d  = (sgn && a[WIDTH-1]) ? (~a + ONE_W) : a;
          mplier_d = (sgn && b[WIDTH-1]) ? (~b + ONE_W) : b;
          neg_d    = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        add_a = acc_q;
        add_b = mplier_q[0] ? mcand_q : '0;
        {acc_d, mplier_d} = {add_co, add_s, mplier_q[WIDTH-1:1]};
        cnt_d = cnt_q + ONE_C;
        if (cnt_q == CNT_END) state_d = ST_FIX;
      end
      ST_FIX: begin
        // Low half ~lo + 1 goes through the adder; its carry-out is the
        // carry-in of the high half ~hi + c.
        add_a  = ~mplier_q;
        add_b  = '0;
        add_ci = 1'b1;
        prod_d = neg_q ? {~acc_q + WIDTH'(add_co), add_s} : {acc_q, mplier_q};
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign product = prod_q;

endmodule

// File: tb/tb_mult_seq.sv
// Directed-vector bench for mult_seq (WIDTH=16): table of operand/product
// records plus hand-written back-to-back and mid-operation reset sequences.
module tb_mult_seq;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           sgn;
  logic [W-1:0]   a, b;
  logic           busy, done;
  logic [2*W-1:0] product;

  int checks = 0;
  int errors = 0;

  mult_seq #(.WIDTH(W), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .sgn     (sgn),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           s;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait (bounded) until done, counting edges from the edge that sampled start.
  task automatic wait_done(input string name, output int lat, output logic busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for done", name);
    end
  endtask

  // Full operation with latency, product, busy and done-pulse checks.
  task automatic run_op(input string name, input logic s, input logic [W-1:0] va,
                        input logic [W-1:0] vb, input logic [2*W-1:0] exp);
    int   lat;
    logic bok;
    int   guard;
    @(negedge clk);
    guard = 0;
    while (busy && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    sgn = s; a = va; b = vb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, " busy@0"}, 64'(busy), 64'd1);
    wait_done(name, lat, bok);
    if (lat >= 0) begin
      chk({name, " latency"}, 64'(lat), 64'd17);
      chk({name, " product"}, 64'(product), 64'(exp));
      chk({name, " busy held"}, 64'(bok), 64'd1);
      @(posedge clk); #1;
      chk({name, " done pulse"}, 64'({done, busy}), 64'd0);
    end
  endtask

  initial begin
    int   lat;
    logic bok;
    int   seen;

    vecs[0] = '{1'b0, 16'h0003, 16'h0005, 32'h0000_000F};
    vecs[1] = '{1'b1, 16'hFFFD, 16'h0007, 32'hFFFF_FFEB};
    vecs[2] = '{1'b1, 16'h8000, 16'h8000, 32'h4000_0000};
    vecs[3] = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vecs[4] = '{1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0001};
    vecs[5] = '{1'b1, 16'h0000, 16'h8001, 32'h0000_0000};
    vecs[6] = '{1'b0, 16'h8000, 16'h8000, 32'h4000_0000};
    vecs[7] = '{1'b1, 16'h7FFF, 16'h8000, 32'hC000_8000};
    vecs[8] = '{1'b0, 16'h1234, 16'h0000, 32'h0000_0000};
    vecs[9] = '{1'b1, 16'h0005, 16'hFFFA, 32'hFFFF_FFE2};

    rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset product", 64'(product), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Start re-pulsed while busy must not disturb the operation in flight.
    @(negedge clk);
    sgn = 1'b0; a = 16'd2; b = 16'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    sgn = 1'b1; a = 16'd9; b = 16'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 6; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    chk("b2b latency", 64'(lat), 64'd17);
    chk("b2b product", 64'(product), 64'd6);
    @(posedge clk); #1;
    chk("b2b idle", 64'(busy), 64'd0);
    // Next start lands in the first idle cycle after DONE.
    run_op("b2b second", 1'b0, 16'd9, 16'd9, 32'd81);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    sgn = 1'b0; a = 16'd5; b = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst product", 64'(product), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk("rst no done", 64'(seen), 64'd0);
    run_op("after rst", 1'b0, 16'd4, 16'd4, 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
